// File: rtl/elevator_car_model.sv
// rtl/elevator_car_model.sv - plant model of elevator car, shaft and door with illegal-command flags
module elevator_car_model #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       door,
    input  logic [1:0] dir,
    output logic [1:0] fs,
    output logic       dc,
    output logic       moving,
    output logic       arrive,
    output logic [2:0] fault
);

    localparam int CW = $clog2(TRAVEL_CYCLES + 1);
    localparam int PW = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TRAVEL_CYCLES - 1);
    localparam logic [PW-1:0] POS_CLOSED = PW'(DOOR_CYCLES);

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_BAD  = 2'b11;

    typedef enum logic {
        STOPPED,
        MOVING
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [PW-1:0] pos, pos_next;
    logic [1:0]    ldir, ldir_next;
    logic [1:0]    fs_next;
    logic          dc_next;
    logic          arrive_next;
    logic [2:0]    fault_next;
    logic          start;
    logic          want_up;
    logic          want_down;

    assign moving = (state == MOVING);

    // State register; async reset puts the car closed and parked at floor 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= STOPPED;
            cnt    <= '0;
            pos    <= POS_CLOSED;
            ldir   <= DIR_IDLE;
            fs     <= 2'b01;
            dc     <= 1'b1;
            arrive <= 1'b0;
            fault  <= 3'b000;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            pos    <= pos_next;
            ldir   <= ldir_next;
            fs     <= fs_next;
            dc     <= dc_next;
            arrive <= arrive_next;
            fault  <= fault_next;
        end
    end

    // Motion FSM, door travel and sticky fault detection
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pos_next    = pos;
        ldir_next   = ldir;
        fs_next     = fs;
        arrive_next = 1'b0;
        fault_next  = fault;
        start       = 1'b0;
        want_up     = (dir == DIR_UP);
        want_down   = (dir == DIR_DOWN);

        if (dir == DIR_BAD) begin
            fault_next[2] = 1'b1;
        end

        case (state)
            STOPPED: begin
                if (dir != DIR_IDLE && !dc) begin
                    fault_next[0] = 1'b1;
                end else if ((want_up && fs == 2'b11) || (want_down && fs == 2'b01)) begin
                    fault_next[1] = 1'b1;
                end else if (want_up || want_down) begin
                    start      = 1'b1;
                    state_next = MOVING;
                    cnt_next   = '0;
                    ldir_next  = dir;
                end
            end
            MOVING: begin
                if (!door) begin
                    fault_next[0] = 1'b1;
                end
                if (cnt != CNT_LAST) begin
                    // Steering away from the latched direction is only illegal before arrival
                    if (dir != ldir) begin
                        fault_next[2] = 1'b1;
                    end
                    cnt_next = cnt + 1'b1;
                end else begin
                    state_next  = STOPPED;
                    arrive_next = 1'b1;
                    cnt_next    = '0;
                    fs_next     = (ldir == DIR_UP) ? fs + 2'b01 : fs - 2'b01;
                end
            end
            default: state_next = STOPPED;
        endcase

        // Door is locked shut from the start edge until the segment completes
        if (state == STOPPED && !start) begin
            if (door && pos != POS_CLOSED) begin
                pos_next = pos + 1'b1;
            end else if (!door && pos != '0) begin
                pos_next = pos - 1'b1;
            end
        end

        dc_next = (pos_next == POS_CLOSED);
    end

endmodule

// File: tb/tb_elevator_car_model.sv
// tb/tb_elevator_car_model.sv - scoreboard bench for elevator_car_model with reference plant
module tb_elevator_car_model;

    localparam int TRAVEL = 8;
    localparam int DOORC  = 3;

    bit         clk;
    logic       rst;
    logic       door;
    logic [1:0] dir;
    logic [1:0] fs;
    logic       dc;
    logic       moving;
    logic       arrive;
    logic [2:0] fault;

    elevator_car_model #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOORC)) dut (
        .clk    (clk),
        .rst    (rst),
        .door   (door),
        .dir    (dir),
        .fs     (fs),
        .dc     (dc),
        .moving (moving),
        .arrive (arrive),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] fs;
        logic       dc;
        logic       moving;
        logic       arrive;
        logic [2:0] fault;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rst_prev = 1'b0;

    // Reference plant: floor number, door openness, edges left in the segment
    int         m_floor;
    int         m_pos;
    int         m_left;
    int         m_dir;
    bit         m_arrive;
    logic [2:0] m_fault;

    task automatic model_step(input logic r, input logic d, input logic [1:0] dr);
        bit closed;
        bit up;
        bit dn;
        if (!r) begin
            m_floor = 1; m_pos = DOORC; m_left = 0; m_dir = 0;
            m_arrive = 0; m_fault = 3'b000;
        end else begin
            closed   = (m_pos == DOORC);
            up       = (dr == 2'd1);
            dn       = (dr == 2'd2);
            m_arrive = 0;
            if (dr == 2'd3) m_fault[2] = 1'b1;
            if (m_left > 0) begin
                if (!d) m_fault[0] = 1'b1;
                if (int'(dr) != m_dir && m_left > 1) m_fault[2] = 1'b1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_floor  = (m_dir == 1) ? m_floor + 1 : m_floor - 1;
                    m_arrive = 1;
                end
            end else begin
                if (dr != 2'd0 && !closed) m_fault[0] = 1'b1;
                else if ((up && m_floor == 3) || (dn && m_floor == 1)) m_fault[1] = 1'b1;
                else if (up || dn) begin
                    m_left = TRAVEL;
                    m_dir  = int'(dr);
                end
                if (m_left == 0) begin
                    if (d) m_pos = (m_pos < DOORC) ? m_pos + 1 : DOORC;
                    else   m_pos = (m_pos > 0) ? m_pos - 1 : 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Apply one cycle of inputs, predict the post-edge outputs and queue them
    task automatic drive(input logic r, input logic d, input logic [1:0] dr);
        obs_t e;
        rst  = r;
        door = d;
        dir  = dr;
        model_step(r, d, dr);
        e.fs = m_floor[1:0]; e.dc = (m_pos == DOORC); e.moving = (m_left > 0);
        e.arrive = m_arrive; e.fault = m_fault;
        exp_q.push_back(e);
        if (!r && rst_prev) begin
            #1;
            chk("reset_immediate", {fs, dc, moving, arrive, fault}, {2'b01, 1'b1, 1'b0, 1'b0, 3'b000});
        end
        rst_prev = r;
        @(negedge clk);
    endtask

    task automatic segment(input logic [1:0] dr);
        for (int i = 0; i <= TRAVEL; i++) drive(1, 1, dr);
    endtask

    // Monitor: compare every post-edge observation against the oldest prediction
    always @(posedge clk) begin
        obs_t e;
        #1;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got fs=%0d no expectation", fs);
        end else begin
            e = exp_q.pop_front();
            if ({fs, dc, moving, arrive, fault} !== e) begin
                n_fail++;
                $display("FAIL cycle_obs t=%0t: got fs=%b dc=%b mv=%b arr=%b flt=%b expected fs=%b dc=%b mv=%b arr=%b flt=%b",
                         $time, fs, dc, moving, arrive, fault, e.fs, e.dc, e.moving, e.arrive, e.fault);
            end
        end
    end

    initial begin
        int         hold;
        int         until_rst;
        logic       rdoor;
        logic [1:0] rdir;
        int         pick;

        // Reset and idle
        drive(0, 1, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 0);
        chk("idle_state", {fs, dc, moving, arrive, fault}, {2'b01, 1'b1, 1'b0, 1'b0, 3'b000});

        // Door open then close
        drive(1, 0, 0);
        chk("door_open_dc", {7'd0, dc}, 8'd0);
        for (int i = 0; i < 5; i++) drive(1, 0, 0);
        drive(1, 1, 0);
        drive(1, 1, 0);
        chk("door_close_e1", {7'd0, dc}, 8'd0);
        drive(1, 1, 0);
        chk("door_close_e2", {7'd0, dc}, 8'd1);

        // Up 1->2 then 2->3
        drive(1, 1, 1);
        chk("up_moving", {7'd0, moving}, 8'd1);
        for (int i = 0; i < TRAVEL - 1; i++) drive(1, 1, 1);
        chk("up_fs_before", {6'd0, fs}, 8'd1);
        drive(1, 1, 1);
        chk("up_fs_arrive", {5'd0, fs, arrive}, {5'd0, 2'b10, 1'b1});
        drive(1, 1, 0);
        chk("up_arrive_clear", {4'd0, arrive, fault}, 8'd0);
        segment(1);
        drive(1, 1, 0);
        chk("up_fs3", {6'd0, fs}, 8'd3);

        // Over-travel at top, then down
        drive(1, 1, 1);
        chk("overtravel", {4'd0, moving, fault}, {4'd0, 1'b0, 3'b010});
        drive(1, 1, 0);
        segment(2);
        drive(1, 1, 0);
        chk("down_fs2", {3'd0, fs, fault}, {3'd0, 2'b10, 3'b010});

        // Door interlock
        drive(1, 0, 0);
        drive(1, 0, 1);
        chk("interlock", {4'd0, moving, fault}, {4'd0, 1'b0, 3'b011});
        for (int i = 0; i < DOORC; i++) drive(1, 1, 0);

        // Direction dropped mid-segment
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(1, 1, 1);
        for (int i = 0; i < 3; i++) drive(1, 1, 1);
        for (int i = 0; i < TRAVEL - 3; i++) drive(1, 1, 0);
        chk("dir_drop", {3'd0, fs, fault}, {3'd0, 2'b10, 3'b100});

        // Reset during a segment
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(1, 1, 1);
        for (int i = 0; i < 4; i++) drive(1, 1, 1);
        drive(0, 1, 1);
        drive(1, 1, 0);

        // Randomized traffic with occasional resets
        hold = 0;
        until_rst = 100;
        rdoor = 1'b1;
        rdir = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                hold  = $urandom_range(1, 20);
                rdoor = ($urandom_range(0, 9) != 0);
                pick  = $urandom_range(0, 31);
                if (pick < 14)      rdir = 2'b00;
                else if (pick < 23) rdir = 2'b01;
                else if (pick < 31) rdir = 2'b10;
                else                rdir = 2'b11;
            end
            if (until_rst == 0) begin
                drive(0, rdoor, rdir);
                until_rst = $urandom_range(20, 250);
            end else begin
                until_rst--;
                hold--;
                drive(1, rdoor, rdir);
            end
        end

        drive(1, 1, 0);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_car_model.md
Name: elevator_car_model

Overview:
- Synthesizable plant model of the elevator car, shaft and door: the opposite end of the controller interface.
- Consumes the controller's door and dir commands. Produces the floor sensor (fs) and door-closed (dc) feedback the controller samples.
- Replaces hand-driven fs/dc stimulus in closed-loop benches, and flags physically illegal command sequences.

Parameters:
TRAVEL_CYCLES  8  clock cycles to move one floor (min 1)
DOOR_CYCLES    3  clock cycles for the door to travel fully open<->closed (min 1)

Ports:
clk     input   1  clock; all state updates on rising edge
rst     input   1  asynchronous, active-low reset
door    input   1  controller door command: 1=close, 0=open
dir     input   2  controller motion command: 00 idle, 01 up, 10 down, 11 illegal
fs      output  2  floor sensor, last floor reached: 01 floor1, 10 floor2, 11 floor3 (never 00)
dc      output  1  door fully closed
moving  output  1  car is between floors
arrive  output  1  one-cycle pulse in the cycle fs takes a new value
fault   output  3  sticky fault flags; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous):
  - fs=01, dc=1, moving=0, arrive=0, fault=000.
  - Door position = DOOR_CYCLES (closed); motion FSM = STOPPED; travel count = 0.
- Door position pos, range 0..DOOR_CYCLES (0 = fully open):
  - Each edge, pos steps one toward the command: +1 if door=1, -1 if door=0.
  - pos saturates at both ends.
  - While moving=1, pos is held at DOOR_CYCLES regardless of door.
  - dc = (pos==DOOR_CYCLES), registered.
  - Timing: from closed, door=0 sampled at edge N gives dc=0 after edge N. From fully open, door=1 sampled at edge N gives dc=1 after edge N+DOOR_CYCLES-1.
- Motion FSM, states STOPPED and MOVING:
  - STOPPED->MOVING on an edge where dir=01 and dc=1 and fs!=11, or dir=10 and dc=1 and fs!=01.
    - Latch direction; cnt=0; moving=1 after that edge.
  - MOVING:
    - cnt increments each edge.
    - On the edge where cnt==TRAVEL_CYCLES-1: fs becomes fs+1 (up) or fs-1 (down); arrive=1 for one cycle; moving=0; state->STOPPED.
    - So fs changes TRAVEL_CYCLES edges after the start edge.
  - The car always completes a started segment. dir changes mid-segment do not stop or reverse it.
  - Back-to-back segments:
    - At least one STOPPED cycle separates two segments.
    - If dir is still non-idle in that cycle, the next segment starts on the following edge, subject to the same conditions.
- Fault flags (set on the edge the condition is sampled; sticky; condition is ignored otherwise):
  - fault[0] door interlock: dir!=00 while dc=0 and STOPPED (no motion starts), or door=0 while MOVING.
  - fault[1] over-travel: dir=01 with fs=11, or dir=10 with fs=01, while STOPPED and dc=1 (no motion starts).
  - fault[2] protocol:
    - dir=11 in any state;
    - in MOVING, dir different from the latched direction (including 00) before the arrival edge.
    - dir=11 never starts motion.
- Simultaneous events: several fault bits may set on the same edge. Door command changes on the start edge take effect only after the segment ends.
- Reset mid-segment: immediate return to reset values. The in-flight segment is discarded and fs returns to 01.
- Widths: cnt and pos are $clog2(max+1) bits. No arithmetic wrap is possible because of the fs range checks.

Test Plan:
- Reset, door=1, dir=00, hold 10 cycles -> fs=01, dc=1, moving=0, arrive=0, fault=000 throughout.
- Door cycle, DOOR_CYCLES=3: door=0 at edge 0 -> dc=0 after edge 0. Hold open 5 edges, then door=1 at edge E -> dc=1 after edge E+2.
- Up 1->2, TRAVEL_CYCLES=8, dc=1: dir=01 at edge S -> moving=1 after S. fs=10 and arrive=1 after S+8. arrive=0 after S+9, fault=000. Repeat 2->3 -> fs=11.
- At fs=11, dir=01 -> no motion, fault=010. Then dir=10 -> fs=10 after 8 edges, fault stays 010.
- door=0 (dc=0), dir=01 -> moving stays 0, fault[0]=1. Separately, dir 01->00 mid-segment -> segment completes (fs advances), fault[2]=1.
- Reset asserted at cnt=4 of a 1->2 segment -> immediately fs=01, moving=0, dc=1, fault=000.
